// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared types and sizes for the framebuffer write path
package fb_pkg;

  localparam int FB_ADDR_W = 10;
  localparam int FB_DATA_W = 8;
  localparam int FB_WORDS  = 1024;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } sched_state_t;

  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [FB_DATA_W-1:0] data;
  } fb_wr_t;

endpackage

// File: rtl/cmd_fifo.sv
// rtl/cmd_fifo.sv - small synchronous FIFO of framebuffer writes with flush
module cmd_fifo
  import fb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  fb_wr_t        push_data,
  input  logic          pop,
  input  logic          flush,
  output fb_wr_t        pop_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  fb_wr_t        mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_next;
  logic [AW-1:0] wr_base;
  logic [AW-1:0] wr_next;
  logic [AW:0]   count_next;
  logic          do_pop;
  logic          do_push;

  assign pop_data = mem[rd_ptr];

  // Flush empties first; a push in the same cycle then lands in slot 0.
  always_comb begin
    do_pop  = pop && !flush && (count != '0);
    do_push = push && (flush || do_pop || (count != DEPTH_C));
    wr_base = flush ? '0 : wr_ptr;
    rd_next = flush ? '0 : (do_pop ? rd_ptr + AW'(1) : rd_ptr);
    wr_next = do_push ? wr_base + AW'(1) : wr_base;
    if (flush) begin
      count_next = do_push ? (AW+1)'(1) : '0;
    end else if (do_push && !do_pop) begin
      count_next = count + (AW+1)'(1);
    end else if (!do_push && do_pop) begin
      count_next = count - (AW+1)'(1);
    end else begin
      count_next = count;
    end
  end

  // Pointers, occupancy and registered full/empty flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      rd_ptr <= rd_next;
      wr_ptr <= wr_next;
      count  <= count_next;
      full   <= (count_next == DEPTH_C);
      empty  <= (count_next == '0);
    end
  end

  // Storage array; contents need no reset since occupancy gates reads.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_base] <= push_data;
    end
  end

endmodule

// File: rtl/fb_write_scheduler.sv
// rtl/fb_write_scheduler.sv - arbitrates the framebuffer write port between decoder writes and the clear sweep
module fb_write_scheduler
  import fb_pkg::*;
#(
  parameter int               ADDR_W      = 10,
  parameter int               DATA_W      = 8,
  parameter int               FIFO_DEPTH  = 4,
  parameter logic [DATA_W-1:0] CLEAR_COLOR = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_waddr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic              clear_req,
  input  logic              ovf_clr,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_waddr,
  output logic [DATA_W-1:0] fb_wdata,
  output logic              clear_busy,
  output logic              fifo_full,
  output logic              overflow
);

  localparam int CW = $clog2(FIFO_DEPTH);

  sched_state_t      state;
  sched_state_t      state_next;
  logic [ADDR_W-1:0] sweep_cnt;
  logic [ADDR_W-1:0] cnt_next;
  logic              resume;
  logic              resume_next;

  logic              pop;
  logic              flush;
  logic              drop;
  fb_wr_t            push_entry;
  fb_wr_t            pop_entry;
  logic              fifo_empty;
  logic [CW:0]       fifo_count;

  logic              we_next;
  logic [ADDR_W-1:0] waddr_next;
  logic [DATA_W-1:0] wdata_next;
  logic              busy_next;
  logic              ovf_next;

  assign push_entry.addr = cmd_waddr;
  assign push_entry.data = cmd_wdata;

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (cmd_we),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (flush),
    .pop_data  (pop_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Next-state, FIFO control and next output values; clear_req overrides everything.
  always_comb begin
    state_next  = state;
    cnt_next    = sweep_cnt;
    resume_next = 1'b0;
    pop         = 1'b0;
    flush       = 1'b0;
    we_next     = 1'b0;
    waddr_next  = fb_waddr;
    wdata_next  = fb_wdata;
    busy_next   = 1'b0;
    case (state)
      IDLE: begin
        // One quiet cycle follows a finished sweep before queued writes drain.
        if (!clear_req && !resume && !fifo_empty) begin
          pop        = 1'b1;
          we_next    = 1'b1;
          waddr_next = pop_entry.addr;
          wdata_next = pop_entry.data;
        end
      end
      CLEAR: begin
        we_next    = 1'b1;
        busy_next  = 1'b1;
        waddr_next = sweep_cnt;
        wdata_next = CLEAR_COLOR;
        cnt_next   = sweep_cnt + ADDR_W'(1);
        if (sweep_cnt == '1) begin
          state_next  = IDLE;
          resume_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    if (clear_req) begin
      flush       = 1'b1;
      state_next  = CLEAR;
      cnt_next    = '0;
      resume_next = 1'b0;
    end
    drop     = cmd_we && !clear_req && !pop && (fifo_count == (CW+1)'(FIFO_DEPTH));
    ovf_next = drop ? 1'b1 : (ovf_clr ? 1'b0 : overflow);
  end

  // State, sweep counter and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      sweep_cnt  <= '0;
      resume     <= 1'b0;
      fb_we      <= 1'b0;
      fb_waddr   <= '0;
      fb_wdata   <= '0;
      clear_busy <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_next;
      sweep_cnt  <= cnt_next;
      resume     <= resume_next;
      fb_we      <= we_next;
      fb_waddr   <= waddr_next;
      fb_wdata   <= wdata_next;
      clear_busy <= busy_next;
      overflow   <= ovf_next;
    end
  end

endmodule

// File: tb/tb_fb_write_scheduler.sv
// tb/tb_fb_write_scheduler.sv - scoreboard bench for fb_write_scheduler
module tb_fb_write_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_we;
  logic [9:0] cmd_waddr;
  logic [7:0] cmd_wdata;
  logic       clear_req;
  logic       ovf_clr;
  logic       fb_we;
  logic [9:0] fb_waddr;
  logic [7:0] fb_wdata;
  logic       clear_busy;
  logic       fifo_full;
  logic       overflow;

  fb_write_scheduler #(
    .ADDR_W      (10),
    .DATA_W      (8),
    .FIFO_DEPTH  (4),
    .CLEAR_COLOR (8'h00)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_we     (cmd_we),
    .cmd_waddr  (cmd_waddr),
    .cmd_wdata  (cmd_wdata),
    .clear_req  (clear_req),
    .ovf_clr    (ovf_clr),
    .fb_we      (fb_we),
    .fb_waddr   (fb_waddr),
    .fb_wdata   (fb_wdata),
    .clear_busy (clear_busy),
    .fifo_full  (fifo_full),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int addr;
    int data;
    int cyc;
    int busy;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_push(input int a, input int d, input int c, input int b);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.cyc  = c;
    e.busy = b;
    sb.push_back(e);
  endtask

  task automatic exp_sweep(input int first_cyc, input int n);
    for (int k = 0; k < n; k++) exp_push(k, 0, first_cyc + k, 1);
  endtask

  task automatic drive(input logic we, input logic [9:0] a, input logic [7:0] d,
                       input logic clr, input logic oc);
    cmd_we    = we;
    cmd_waddr = a;
    cmd_wdata = d;
    clear_req = clr;
    ovf_clr   = oc;
    @(negedge clk);
    cmd_we    = 1'b0;
    clear_req = 1'b0;
    ovf_clr   = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_fb_we"},      32'(fb_we),      32'd0);
    check({tag, "_fb_waddr"},   32'(fb_waddr),   32'd0);
    check({tag, "_fb_wdata"},   32'(fb_wdata),   32'd0);
    check({tag, "_clear_busy"}, 32'(clear_busy), 32'd0);
    check({tag, "_fifo_full"},  32'(fifo_full),  32'd0);
    check({tag, "_overflow"},   32'(overflow),   32'd0);
  endtask

  // Monitor: every framebuffer write is matched against the head of the scoreboard.
  always @(negedge clk) begin
    if (reset === 1'b1 && fb_we === 1'b1) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, required no write (cycle %0d)",
                 fb_waddr, fb_wdata, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wr_addr",  32'(fb_waddr),   32'(e.addr));
        check("wr_data",  32'(fb_wdata),   32'(e.data));
        check("wr_cycle", 32'(cyc),        32'(e.cyc));
        check("wr_busy",  32'(clear_busy), 32'(e.busy));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t;
    reset     = 1'b0;
    cmd_we    = 1'b0;
    cmd_waddr = '0;
    cmd_wdata = '0;
    clear_req = 1'b0;
    ovf_clr   = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;
    @(negedge clk);

    // Back-to-back decoder writes in IDLE.
    t = cyc + 1;
    exp_push(10'h021, 8'h05, t + 1, 0);
    exp_push(10'h3FF, 8'h02, t + 2, 0);
    exp_push(10'h000, 8'h07, t + 3, 0);
    drive(1'b1, 10'h021, 8'h05, 1'b0, 1'b0);
    drive(1'b1, 10'h3FF, 8'h02, 1'b0, 1'b0);
    drive(1'b1, 10'h000, 8'h07, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    check("b2b_fifo_full", 32'(fifo_full), 32'd0);

    // Full sweep with five decoder writes arriving during it.
    t = cyc + 1;
    exp_sweep(t + 1, 1024);
    for (int i = 0; i < 4; i++) exp_push(10'h100 + i, 8'h10 + i, t + 1026 + i, 0);
    drive(1'b0, 10'h000, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 10'(10'h100 + i), 8'(8'h10 + i), 1'b0, 1'b0);
      if (i == 3) check("clear_fifo_full_at4", 32'(fifo_full), 32'd1);
      if (i == 3) check("clear_no_ovf_at4",    32'(overflow),  32'd0);
    end
    check("clear_overflow_set", 32'(overflow), 32'd1);
    check("clear_busy_mid",     32'(clear_busy), 32'd1);
    wait_until(t + 1025);
    check("sweep_end_busy", 32'(clear_busy), 32'd0);
    check("sweep_end_we",   32'(fb_we),      32'd0);
    wait_until(t + 1032);
    check("drain_fifo_full",  32'(fifo_full), 32'd0);
    check("overflow_sticky",  32'(overflow),  32'd1);
    drive(1'b0, 10'h000, 8'h00, 1'b0, 1'b1);
    check("overflow_cleared", 32'(overflow),  32'd0);
    repeat (3) @(negedge clk);

    // Two queued writes flushed by a restart at counter 700 with a same-cycle push.
    t = cyc + 1;
    exp_sweep(t + 1, 701);
    exp_sweep(t + 702, 1024);
    exp_push(10'h155, 8'h03, t + 1727, 0);
    drive(1'b0, 10'h000, 8'h00, 1'b1, 1'b0);
    drive(1'b1, 10'h011, 8'h0A, 1'b0, 1'b0);
    drive(1'b1, 10'h012, 8'h0B, 1'b0, 1'b0);
    wait_until(t + 700);
    drive(1'b1, 10'h155, 8'h03, 1'b1, 1'b0);
    check("restart_busy", 32'(clear_busy), 32'd1);
    wait_until(t + 1726);
    check("restart_end_busy", 32'(clear_busy), 32'd0);
    check("restart_end_we",   32'(fb_we),      32'd0);
    wait_until(t + 1735);
    check("restart_no_ovf",   32'(overflow),   32'd0);

    // Asynchronous reset in the middle of a sweep with a queued write.
    t = cyc + 1;
    exp_sweep(t + 1, 500);
    drive(1'b0, 10'h000, 8'h00, 1'b1, 1'b0);
    drive(1'b1, 10'h0AA, 8'h55, 1'b0, 1'b0);
    wait_until(t + 500);
    #1;
    reset = 1'b0;
    #1;
    check_all_zero("async_reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("post_reset_we", 32'(fb_we), 32'd0);
    end
    check("post_reset_full", 32'(fifo_full), 32'd0);
    check("post_reset_busy", 32'(clear_busy), 32'd0);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
